// File: rtl/minimax_mem_bridge.sv
// Purpose: memory-side bridge between the minimax core and four 512x32 SRAM banks.
// Latency: reads/fetches 1 cycle; full-word store 1 cycle; partial store 2 cycles (RMW).
// Backpressure: busy is asserted across both RMW cycles; the core holds its requests meanwhile.
//
// Ports: clk/reset (sync, active-high); inst_addr/inst_regce/inst = fetch path;
//   addr/wdata/wmask/rreq/rdata/busy = data path; mem_* = shared bank port.
// Optional build macro MINIMAX_MEM_BRIDGE_EXIT_EN adds halt/halt_code, set by a
//   full-word store to 32'hfffffffc.
module minimax_mem_bridge #(
    parameter int          PC_BITS    = 13,
    parameter logic [15:0] INST_RESET = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_BITS-1:0] inst_addr,
    input  logic               inst_regce,
    output logic [15:0]        inst,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic [3:0]         wmask,
    input  logic               rreq,
    output logic [31:0]        rdata,
    output logic               busy,
    output logic [3:0]         mem_en,
    output logic [8:0]         mem_addr,
    output logic [31:0]        mem_wdata,
    output logic               mem_wen,
    input  logic [127:0]       mem_rdata
`ifdef MINIMAX_MEM_BRIDGE_EXIT_EN
    ,
    output logic               halt,
    output logic [31:0]        halt_code
`endif
);

    typedef enum logic {IDLE, RMW_WRITE} state_t;

    state_t      state;
    logic [12:2] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic [31:0] rmw_word_q;
    logic [15:0] inst_latch;

    logic [31:0] fetch_addr;
    logic        data_req;
    logic        in_range;
    logic        full_store;
    logic        part_store;
    logic [31:0] data_word;
    logic [31:0] fetch_word;
    logic [31:0] merged;

    assign fetch_addr = 32'(inst_addr);
    assign data_req   = rreq | (|wmask);
    assign in_range   = (addr[31:13] == 19'd0);
    assign full_store = (wmask == 4'hf);
    assign part_store = (|wmask) && !full_store;
    assign data_word  = mem_rdata[{addr[12:11], 5'd0} +: 32];
    assign fetch_word = mem_rdata[{fetch_addr[12:11], 5'd0} +: 32];

    // Bits that do not take part in word addressing.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], fetch_addr[31:13], fetch_addr[0]};

    // Byte merge uses only latched store data, so late changes on wmask/wdata are ignored.
    always_comb begin
        merged = rmw_word_q;
        for (int i = 0; i < 4; i++) begin
            if (wmask_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    // Bank port: RMW write owns it, then any data access, else the fetch.
    // Everything is forced idle while reset is high so an abandoned store never writes.
    always_comb begin
        mem_en    = 4'b0000;
        mem_addr  = 9'd0;
        mem_wdata = 32'd0;
        mem_wen   = 1'b0;
        busy      = 1'b0;
        if (!reset) begin
            if (state == RMW_WRITE) begin
                mem_en    = 4'b0001 << addr_q[12:11];
                mem_addr  = addr_q[10:2];
                mem_wdata = merged;
                mem_wen   = 1'b1;
                busy      = 1'b1;
            end else if (data_req) begin
                mem_addr = addr[10:2];
                if (in_range) begin
                    mem_en = 4'b0001 << addr[12:11];
                    if (full_store) begin
                        mem_wen   = 1'b1;
                        mem_wdata = wdata;
                    end else if (part_store) begin
                        busy = 1'b1;
                    end
                end
            end else begin
                mem_en   = 4'b0001 << fetch_addr[12:11];
                mem_addr = fetch_addr[10:2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rdata      <= 32'd0;
            inst       <= INST_RESET;
            inst_latch <= INST_RESET;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            wmask_q    <= 4'd0;
            rmw_word_q <= 32'd0;
`ifdef MINIMAX_MEM_BRIDGE_EXIT_EN
            halt       <= 1'b0;
            halt_code  <= 32'd0;
`endif
        end else begin
            if (inst_regce) inst <= inst_latch;
            case (state)
                IDLE: begin
                    if (data_req) begin
                        if (part_store && in_range) begin
                            addr_q     <= addr[12:2];
                            wdata_q    <= wdata;
                            wmask_q    <= wmask;
                            rmw_word_q <= data_word;
                            state      <= RMW_WRITE;
                        end else if (wmask == 4'd0) begin
                            rdata <= in_range ? data_word : 32'd0;
                        end
`ifdef MINIMAX_MEM_BRIDGE_EXIT_EN
                        // Only the first exit store is recorded.
                        if (full_store && addr == 32'hfffffffc && !halt) begin
                            halt      <= 1'b1;
                            halt_code <= wdata;
                        end
`endif
                    end else begin
                        inst_latch <= fetch_addr[1] ? fetch_word[31:16] : fetch_word[15:0];
                    end
                end
                RMW_WRITE: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minimax_mem_bridge.sv
// Purpose: directed self-checking bench for minimax_mem_bridge with a behavioural 4-bank SRAM.
// Latency: checks combinational bank outputs mid-cycle and registered outputs after each edge.
// Backpressure: busy is checked cycle by cycle across each RMW sequence.
module tb_minimax_mem_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic [12:0]  inst_addr;
    logic         inst_regce;
    logic [15:0]  inst;
    logic [31:0]  addr, wdata, rdata, mem_wdata;
    logic [3:0]   wmask, mem_en;
    logic         rreq, busy, mem_wen;
    logic [8:0]   mem_addr;
    logic [127:0] mem_rdata;
`ifdef MINIMAX_MEM_BRIDGE_EXIT_EN
    logic         halt;
    logic [31:0]  halt_code;
`endif

    int cmp = 0;
    int err = 0;
    int wr_count = 0;

    // Bank model: read data valid in the enable cycle, write on the rising edge.
    logic [31:0] mem [4][512];
    logic        pl_vld = 1'b0;
    logic [1:0]  pl_bank;
    logic [8:0]  pl_idx;
    logic [31:0] pl_dat;

    always #5 clk = ~clk;

    always_comb begin
        mem_rdata = '0;
        for (int k = 0; k < 4; k++) mem_rdata[32*k +: 32] = mem[k][mem_addr];
    end

    always @(posedge clk) begin
        if (pl_vld) begin
            mem[pl_bank][pl_idx] = pl_dat;
        end else if (mem_wen) begin
            wr_count = wr_count + 1;
            for (int k = 0; k < 4; k++) if (mem_en[k]) mem[k][mem_addr] = mem_wdata;
        end
    end

    minimax_mem_bridge #(.PC_BITS(13), .INST_RESET(16'h0000)) dut (
        .clk(clk), .reset(reset), .inst_addr(inst_addr), .inst_regce(inst_regce),
        .inst(inst), .addr(addr), .wdata(wdata), .wmask(wmask), .rreq(rreq),
        .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
`ifdef MINIMAX_MEM_BRIDGE_EXIT_EN
        , .halt(halt), .halt_code(halt_code)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [1:0] b, input logic [8:0] i, input logic [31:0] d);
        pl_bank = b; pl_idx = i; pl_dat = d; pl_vld = 1'b1;
        step;
        pl_vld = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; inst_addr = 13'd0; inst_regce = 1'b0;
        addr = 32'd0; wdata = 32'd0; wmask = 4'd0; rreq = 1'b0;
        for (int i = 0; i < 512; i++) for (int k = 0; k < 4; k++) mem[k][i] = 32'd0;
        step; step;
        @(negedge clk);
        cmp++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", busy); end
        cmp++; if (mem_en !== 4'b0000) begin err++; $display("FAIL reset_mem_en: got %b want 0000", mem_en); end
        cmp++; if (mem_wen !== 1'b0) begin err++; $display("FAIL reset_mem_wen: got %b want 0", mem_wen); end
        cmp++; if (rdata !== 32'd0) begin err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        cmp++; if (inst !== 16'h0000) begin err++; $display("FAIL reset_inst: got %h want 0000", inst); end
        step;
        reset = 1'b0;
        @(negedge clk);
        cmp++; if (mem_en !== 4'b0001) begin err++; $display("FAIL idle_fetch_en: got %b want 0001", mem_en); end
    endtask

    task automatic test_fetch;
        preload(2'd0, 9'd0, 32'h12345678);
        inst_addr = 13'h002; inst_regce = 1'b0;
        @(negedge clk);
        cmp++; if (mem_en !== 4'b0001 || mem_addr !== 9'd0) begin err++; $display("FAIL fetch_port: got en=%b addr=%0d want 0001/0", mem_en, mem_addr); end
        step;
        cmp++; if (inst !== 16'h0000) begin err++; $display("FAIL fetch_hold: got %h want 0000", inst); end
        inst_regce = 1'b1;
        step;
        cmp++; if (inst !== 16'h1234) begin err++; $display("FAIL fetch_hi: got %h want 1234", inst); end
        inst_regce = 1'b0; inst_addr = 13'h000;
        step;
        cmp++; if (inst !== 16'h1234) begin err++; $display("FAIL fetch_regce0: got %h want 1234", inst); end
        inst_regce = 1'b1;
        step;
        cmp++; if (inst !== 16'h5678) begin err++; $display("FAIL fetch_lo: got %h want 5678", inst); end
        inst_regce = 1'b0;
    endtask

    task automatic test_read;
        preload(2'd1, 9'd1, 32'hDEADBEEF);
        rreq = 1'b1; addr = 32'h0000_0804;
        @(negedge clk);
        cmp++; if (mem_en !== 4'b0010 || mem_addr !== 9'd1) begin err++; $display("FAIL read_port: got en=%b addr=%0d want 0010/1", mem_en, mem_addr); end
        cmp++; if (busy !== 1'b0 || mem_wen !== 1'b0) begin err++; $display("FAIL read_busy_wen: got %b/%b want 0/0", busy, mem_wen); end
        step;
        rreq = 1'b0;
        cmp++; if (rdata !== 32'hDEADBEEF) begin err++; $display("FAIL read_rdata: got %h want deadbeef", rdata); end
    endtask

    task automatic test_partial_store;
        int w0;
        preload(2'd2, 9'd0, 32'hAABBCCDD);
        w0 = wr_count;
        addr = 32'h0000_1000; wdata = 32'h0000_5500; wmask = 4'b0010;
        @(negedge clk);
        cmp++; if (busy !== 1'b1 || mem_wen !== 1'b0) begin err++; $display("FAIL rmw_rd_cycle: got busy=%b wen=%b want 1/0", busy, mem_wen); end
        cmp++; if (mem_en !== 4'b0100) begin err++; $display("FAIL rmw_rd_en: got %b want 0100", mem_en); end
        step;
        // Latched values must be used even if the inputs wander.
        wmask = 4'b0001; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        cmp++; if (busy !== 1'b1 || mem_wen !== 1'b1 || mem_en !== 4'b0100) begin err++; $display("FAIL rmw_wr_cycle: got busy=%b wen=%b en=%b want 1/1/0100", busy, mem_wen, mem_en); end
        cmp++; if (mem_wdata !== 32'hAABB55DD) begin err++; $display("FAIL rmw_merge: got %h want aabb55dd", mem_wdata); end
        step;
        wmask = 4'd0; wdata = 32'd0;
        @(negedge clk);
        cmp++; if (busy !== 1'b0 || mem_en !== 4'b0001) begin err++; $display("FAIL rmw_done: got busy=%b en=%b want 0/0001", busy, mem_en); end
        cmp++; if (mem[2][0] !== 32'hAABB55DD) begin err++; $display("FAIL rmw_mem: got %h want aabb55dd", mem[2][0]); end
        cmp++; if (wr_count - w0 !== 1) begin err++; $display("FAIL rmw_wr_count: got %0d want 1", wr_count - w0); end
    endtask

    task automatic test_back_to_back;
        step;
        addr = 32'h0000_1FFC; wdata = 32'h1122_3344; wmask = 4'hf;
        @(negedge clk);
        cmp++; if (busy !== 1'b0 || mem_wen !== 1'b1 || mem_wdata !== 32'h11223344) begin err++; $display("FAIL full_store: got busy=%b wen=%b wd=%h want 0/1/11223344", busy, mem_wen, mem_wdata); end
        cmp++; if (mem_en !== 4'b1000 || mem_addr !== 9'd511) begin err++; $display("FAIL full_port: got en=%b addr=%0d want 1000/511", mem_en, mem_addr); end
        step;
        addr = 32'h0000_0000; wdata = 32'h0000_00AA; wmask = 4'b0001;
        @(negedge clk);
        cmp++; if (busy !== 1'b1 || mem_wen !== 1'b0 || mem_en !== 4'b0001) begin err++; $display("FAIL b2b_rd: got busy=%b wen=%b en=%b want 1/0/0001", busy, mem_wen, mem_en); end
        step;
        @(negedge clk);
        cmp++; if (mem_wen !== 1'b1 || mem_wdata !== 32'h123456AA) begin err++; $display("FAIL b2b_wr: got wen=%b wd=%h want 1/123456aa", mem_wen, mem_wdata); end
        step;
        cmp++; if (mem[3][511] !== 32'h11223344) begin err++; $display("FAIL full_mem: got %h want 11223344", mem[3][511]); end
        cmp++; if (rdata !== 32'hDEADBEEF) begin err++; $display("FAIL store_no_rdata: got %h want deadbeef", rdata); end
        // Reset lands on the read cycle of a new RMW.
        wdata = 32'h0000_BB00; wmask = 4'b0010; reset = 1'b1;
        @(negedge clk);
        cmp++; if (busy !== 1'b0 || mem_wen !== 1'b0) begin err++; $display("FAIL rst_rmw_rd: got busy=%b wen=%b want 0/0", busy, mem_wen); end
        step;
        reset = 1'b0; wmask = 4'd0;
        @(negedge clk);
        cmp++; if (busy !== 1'b0 || mem_wen !== 1'b0) begin err++; $display("FAIL rst_rmw_idle: got busy=%b wen=%b want 0/0", busy, mem_wen); end
        step;
        cmp++; if (mem[0][0] !== 32'h123456AA) begin err++; $display("FAIL rst_rmw_mem: got %h want 123456aa", mem[0][0]); end
    endtask

    task automatic test_out_of_range;
        int w0;
        w0 = wr_count;
        rreq = 1'b1; addr = 32'h0001_0000;
        @(negedge clk);
        cmp++; if (mem_en !== 4'b0000) begin err++; $display("FAIL oor_rd_en: got %b want 0000", mem_en); end
        step;
        rreq = 1'b0;
        cmp++; if (rdata !== 32'd0) begin err++; $display("FAIL oor_rdata: got %h want 0", rdata); end
        wmask = 4'hf; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        cmp++; if (mem_wen !== 1'b0 || mem_en !== 4'b0000 || busy !== 1'b0) begin err++; $display("FAIL oor_full: got wen=%b en=%b busy=%b want 0/0000/0", mem_wen, mem_en, busy); end
        step;
        wmask = 4'b0011;
        @(negedge clk);
        cmp++; if (busy !== 1'b0 || mem_wen !== 1'b0) begin err++; $display("FAIL oor_part: got busy=%b wen=%b want 0/0", busy, mem_wen); end
        step;
        @(negedge clk);
        cmp++; if (busy !== 1'b0 || mem_wen !== 1'b0) begin err++; $display("FAIL oor_part2: got busy=%b wen=%b want 0/0", busy, mem_wen); end
        step;
        wmask = 4'd0;
        cmp++; if (wr_count !== w0) begin err++; $display("FAIL oor_writes: got %0d want 0", wr_count - w0); end
    endtask

    task automatic test_exit;
        addr = 32'hFFFF_FFFC; wdata = 32'd0; wmask = 4'hf;
`ifdef MINIMAX_MEM_BRIDGE_EXIT_EN
        cmp++; if (halt !== 1'b0) begin err++; $display("FAIL exit_pre: got %b want 0", halt); end
        step;
        wdata = 32'd7;
        cmp++; if (halt !== 1'b1 || halt_code !== 32'd0) begin err++; $display("FAIL exit_set: got halt=%b code=%h want 1/0", halt, halt_code); end
        step;
        wmask = 4'd0;
        cmp++; if (halt !== 1'b1 || halt_code !== 32'd0) begin err++; $display("FAIL exit_sticky: got halt=%b code=%h want 1/0", halt, halt_code); end
`else
        @(negedge clk);
        cmp++; if (mem_en !== 4'b0000 || mem_wen !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL exit_drop: got en=%b wen=%b busy=%b want 0000/0/0", mem_en, mem_wen, busy); end
        step;
        wmask = 4'd0;
`endif
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_read;
        test_partial_store;
        test_back_to_back;
        test_out_of_range;
        test_exit;
        step;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule

// File: doc/minimax_mem_bridge.md
Name: minimax_mem_bridge

Overview:
- Memory-side stage directly downstream of the minimax core. It is the only path between the core's instruction and data buses and the four 512x32 single-port SRAM banks (8 KiB total).
- Arbitrates fetch against data access and decodes addresses to banks.
- Registers instruction halfwords and read data back to the core.
- Banks support only full-word writes, so the bridge performs byte/halfword stores as a two-cycle read-modify-write (RMW).

Parameters:
- PC_BITS, 13: width of the instruction address from the core.
- INST_RESET, 16'h0000: reset value of the inst output register.

Ports:
- clk  in  1: system clock.
- reset  in  1: synchronous, active-high reset.
- inst_addr  in  PC_BITS: instruction fetch byte address.
- inst_regce  in  1: load enable for the inst register.
- inst  out  16: instruction halfword to the core.
- addr  in  32: data byte address.
- wdata  in  32: store data, byte-lane aligned.
- wmask  in  4: byte write enables. 0 means no store.
- rreq  in  1: data read request.
- rdata  out  32: registered read data.
- busy  out  1: stall request. While high, the core holds addr/wdata/wmask/inst_addr.
- mem_en  out  4: one-hot bank enable.
- mem_addr  out  9: word address within the bank.
- mem_wdata  out  32: bank write data.
- mem_wen  out  1: bank write strobe, full word.
- mem_rdata  in  128: bank read data, bank k on bits [32k+31:32k]. Valid in the same clk cycle the bank is enabled (opposite-edge SRAM).

Behaviour:
Reset:
- state=IDLE; rdata=0; inst=INST_RESET; busy=0; mem_en=0; mem_wen=0.
- Reset during RMW abandons the store. No bank write occurs in the cycle reset is high.

Address decode:
- Bank = a[12:11]; mem_addr = a[10:2].
- Data addresses with addr[31:13]!=0 are out of range:
  - no mem_en;
  - reads return 0;
  - stores are dropped.

Arbitration (IDLE):
- A data access (rreq=1 or wmask!=0) owns the bank port; otherwise inst_addr is presented.
- The fetch is not retried by the bridge; the core re-issues it because busy/data cycles are visible to it.

Reads:
- Cycle N: bank enabled.
- mem_rdata of the enabled bank is muxed and registered into rdata at the end of N, so rdata is valid in N+1.
- Fetch: the halfword selected by inst_addr[1] (0 = low, 1 = high) is registered into an internal latch at the end of N.
- inst loads from the latch on clock edges where inst_regce=1. With inst_regce=0, inst holds its value.

Full-word store (wmask=4'hf):
- Single cycle: mem_wen=1, mem_wdata=wdata, busy=0.
- rdata is not updated.

Partial store (wmask not 0 and not 4'hf):
- IDLE cycle N:
  - read the target word;
  - latch addr, wdata, wmask;
  - busy=1 combinationally;
  - next state RMW_WRITE.
- RMW_WRITE cycle N+1:
  - mem_wdata = per-byte merge: byte i from wdata if wmask[i], else from the word read in N;
  - mem_wen=1, busy=1;
  - next state IDLE.
- Total of 2 cycles. Fetch is blocked in both.
- rreq together with wmask!=0 is treated as the store; rdata is not updated.

Simultaneous/boundary cases:
- Back-to-back partial stores each take 2 cycles. A new store is sampled only in IDLE.
- wmask changes during RMW_WRITE are ignored because latched values are used.
- An out-of-range partial store does not enter RMW (busy stays 0).

Optional Feature:
MINIMAX_MEM_BRIDGE_EXIT_EN:
- When defined, adds outputs halt (1) and halt_code (32), both reset 0.
- A full-word store to 32'hfffffffc sets halt=1 and captures halt_code=wdata on the next edge.
- halt is sticky until reset; later exit stores do not change halt_code.
- When undefined, these ports are absent and the address is an ordinary out-of-range drop.

Test Plan:
- Reset, then fetch at inst_addr=0x002 with the bank0 word 0x12345678 and inst_regce=1 -> inst=0x1234 one cycle after the latch; with inst_regce=0 inst stays 0x0000.
- rreq with addr=0x0804, bank1 word 0xDEADBEEF -> mem_en=4'b0010, mem_addr=1, rdata=0xDEADBEEF in the next cycle, busy=0.
- Word at 0x1000 = 0xAABBCCDD, store wmask=4'b0010, wdata=0x00005500 -> busy high 2 cycles, single mem_wen writes 0xAABB55DD, fetch suppressed during both cycles.
- Full store 0x11223344 to 0x1FFC followed immediately by a partial store to 0x0000 -> first write in 1 cycle with busy=0, then a 2-cycle RMW. Assert reset during the RMW read cycle -> no mem_wen, state IDLE.
- Read of addr 0x00010000 -> mem_en=0, rdata=0. Store there -> no mem_wen.
- With EXIT_EN defined: store wmask=4'hf of 0 to 0xfffffffc -> halt=1, halt_code=0. A second store of 7 leaves halt_code=0. Without EXIT_EN: no bank activity.
